// File: rtl/sif_wa_responder.sv
// sif_wa_responder
//   WA-side target of the SIF link. Decodes the write/read strobes, holds a
//   DEPTH-entry register file, returns read data after RD_LAT cycles and
//   flags rejected or illegal operations.
//
//   Ports
//     clk          clock, rising edge
//     rst_n        asynchronous active-low reset
//     wa_wr_s      write strobe (one cycle per op)
//     wa_rd_s      read strobe (one cycle per op)
//     wa_addr      address, sampled with either strobe
//     wa_data_in   write data, sampled with wa_wr_s
//     wa_data_out  read data, non-zero only while wa_rd_valid=1
//     wa_rd_valid  one-cycle read-response pulse
//     wa_busy      read in flight
//     wa_err       one-cycle pulse for a rejected or illegal op
//     wa_err_cnt   saturating count of wa_err pulses
module sif_wa_responder #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wa_wr_s,
   input  logic              wa_rd_s,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wa_data_in,
   output logic [DATA_W-1:0] wa_data_out,
   output logic              wa_rd_valid,
   output logic              wa_busy,
   output logic              wa_err,
   output logic [7:0]        wa_err_cnt
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      LAT_M1  = 4'(RD_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdat_q;
   logic              err_q;
   logic [7:0]        err_cnt_q;

   logic              in_range;
   logic              locked;
   logic              op_wr, op_rd, op_ill;
   logic              wr_acc, rd_acc;
   logic              err_d;
   logic [IDX_W-1:0]  idx;

   // Upper address bits only matter for the range check.
   assign idx      = wa_addr[IDX_W-1:0];
   assign in_range = ({1'b0, wa_addr} < DEPTH_C);

   assign op_wr  =  wa_wr_s & ~wa_rd_s;
   assign op_rd  = ~wa_wr_s &  wa_rd_s;
   assign op_ill =  wa_wr_s &  wa_rd_s;

   // RESP is the last cycle of a read: strobes sampled at the edge that ends
   // it are accepted, so back-to-back reads are spaced RD_LAT+1 cycles.
   assign locked = (state_q == S_WAIT);
   assign wr_acc = op_wr & ~locked & in_range;
   assign rd_acc = op_rd & ~locked & in_range;

   // All error causes collapse into one pulse.
   assign err_d  = op_ill | ((wa_wr_s | wa_rd_s) & (locked | ~in_range));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. WAIT covers the capture cycle plus RD_LAT-1 more.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_RESP: begin
            if (rd_acc) begin
               state_d = S_WAIT;
               cnt_d   = LAT_M1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register file, read snapshot and error bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rdat_q    <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         if (wr_acc) mem_q[idx] <= wa_data_in;
         // Snapshot at the sample edge; later writes cannot alter the reply.
         if (rd_acc) rdat_q <= mem_q[idx];
         err_q <= err_d;
         if (err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   // Output logic
   always_comb begin
      wa_rd_valid = (state_q == S_RESP);
      wa_busy     = (state_q != S_IDLE);
      wa_data_out = wa_rd_valid ? rdat_q : '0;
      wa_err      = err_q;
      wa_err_cnt  = err_cnt_q;
   end

endmodule
